// File: rtl/fmap_scan_ctrl.sv
// Feature-map window scanner: walks rows/cols row-major and streams
// base + row*pitch + col through a three-register issue/multiply/add pipeline.
//
// state | meaning
// IDLE  | waiting for start; cfg_* latched when start is accepted
// SCAN  | issue stage stepping row/col, one beat per free issue slot
// DRAIN | last beat issued (or empty window); wait for pipeline to empty
module fmap_scan_ctrl #(
  parameter int ADDR_W = 25,
  parameter int IDX_W  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W-1:0]  cfg_rows,
  input  logic [IDX_W-1:0]  cfg_cols,
  input  logic [IDX_W-1:0]  cfg_pitch,
  input  logic [ADDR_W-1:0] cfg_base,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  addr_row,
  output logic [IDX_W-1:0]  addr_col,
  output logic              addr_last,
  output logic              busy,
  output logic              done
);

  localparam int PROD_W = 2 * IDX_W;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]  rows_q, rows_d;
  logic [IDX_W-1:0]  cols_q, cols_d;
  logic [IDX_W-1:0]  pitch_q, pitch_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  row_q, row_d;
  logic [IDX_W-1:0]  col_q, col_d;
  logic              done_q, done_d;

  logic              iss_valid_q, iss_valid_d;
  logic [IDX_W-1:0]  iss_row_q, iss_row_d;
  logic [IDX_W-1:0]  iss_col_q, iss_col_d;
  logic              iss_last_q, iss_last_d;

  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_prod_q, s1_prod_d;
  logic [IDX_W-1:0]  s1_row_q, s1_row_d;
  logic [IDX_W-1:0]  s1_col_q, s1_col_d;
  logic              s1_last_q, s1_last_d;

  logic              s2_valid_q, s2_valid_d;
  logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
  logic [IDX_W-1:0]  s2_row_q, s2_row_d;
  logic [IDX_W-1:0]  s2_col_q, s2_col_d;
  logic              s2_last_q, s2_last_d;

  logic s2_ready, s1_ready, iss_ready;
  logic at_last, at_row_end;

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    pitch_d     = pitch_q;
    base_d      = base_q;
    row_d       = row_q;
    col_d       = col_q;
    done_d      = 1'b0;
    iss_valid_d = iss_valid_q;
    iss_row_d   = iss_row_q;
    iss_col_d   = iss_col_q;
    iss_last_d  = iss_last_q;
    s1_valid_d  = s1_valid_q;
    s1_prod_d   = s1_prod_q;
    s1_row_d    = s1_row_q;
    s1_col_d    = s1_col_q;
    s1_last_d   = s1_last_q;
    s2_valid_d  = s2_valid_q;
    s2_addr_d   = s2_addr_q;
    s2_row_d    = s2_row_q;
    s2_col_d    = s2_col_q;
    s2_last_d   = s2_last_q;

    // Each register advances when empty or when its successor advances.
    s2_ready  = !s2_valid_q || addr_ready;
    s1_ready  = !s1_valid_q || s2_ready;
    iss_ready = !iss_valid_q || s1_ready;

    at_row_end = (col_q == cols_q - IDX_ONE);
    at_last    = at_row_end && (row_q == rows_q - IDX_ONE);

    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_addr_d = base_q + s1_prod_q + ADDR_W'(s1_col_q);
        s2_row_d  = s1_row_q;
        s2_col_d  = s1_col_q;
        s2_last_d = s1_last_q;
      end
    end

    if (s1_ready) begin
      s1_valid_d = iss_valid_q;
      if (iss_valid_q) begin
        s1_prod_d = ADDR_W'(PROD_W'(iss_row_q) * PROD_W'(pitch_q));
        s1_row_d  = iss_row_q;
        s1_col_d  = iss_col_q;
        s1_last_d = iss_last_q;
      end
    end

    if (iss_ready) begin
      iss_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          rows_d  = cfg_rows;
          cols_d  = cfg_cols;
          pitch_d = cfg_pitch;
          base_d  = cfg_base;
          row_d   = '0;
          col_d   = '0;
          if (cfg_rows == '0 || cfg_cols == '0) begin
            state_d = DRAIN;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (iss_ready) begin
          iss_valid_d = 1'b1;
          iss_row_d   = row_q;
          iss_col_d   = col_q;
          iss_last_d  = at_last;
          if (at_last) begin
            state_d = DRAIN;
          end else if (at_row_end) begin
            col_d = '0;
            row_d = row_q + IDX_ONE;
          end else begin
            col_d = col_q + IDX_ONE;
          end
        end
      end
      DRAIN: begin
        // Finish on the edge that retires the final beat, so done follows it directly.
        if (!iss_valid_q && !s1_valid_q && s2_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d     = IDLE;
      done_d      = 1'b0;
      iss_valid_d = 1'b0;
      s1_valid_d  = 1'b0;
      s2_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      pitch_q     <= '0;
      base_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      done_q      <= 1'b0;
      iss_valid_q <= 1'b0;
      iss_row_q   <= '0;
      iss_col_q   <= '0;
      iss_last_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_addr_q   <= '0;
      s2_row_q    <= '0;
      s2_col_q    <= '0;
      s2_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      pitch_q     <= pitch_d;
      base_q      <= base_d;
      row_q       <= row_d;
      col_q       <= col_d;
      done_q      <= done_d;
      iss_valid_q <= iss_valid_d;
      iss_row_q   <= iss_row_d;
      iss_col_q   <= iss_col_d;
      iss_last_q  <= iss_last_d;
      s1_valid_q  <= s1_valid_d;
      s1_prod_q   <= s1_prod_d;
      s1_row_q    <= s1_row_d;
      s1_col_q    <= s1_col_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_addr_q   <= s2_addr_d;
      s2_row_q    <= s2_row_d;
      s2_col_q    <= s2_col_d;
      s2_last_q   <= s2_last_d;
    end
  end

  assign addr_valid = s2_valid_q;
  assign addr       = s2_addr_q;
  assign addr_row   = s2_row_q;
  assign addr_col   = s2_col_q;
  assign addr_last  = s2_last_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

endmodule

// File: doc/fmap_scan_ctrl.md
# fmap_scan_ctrl

Scan controller that walks a feature-map window row-major and issues one linear memory address per beat: addr = base + row·pitch + col. It sits between the layer sequencer (start/done) and the feature-map memory read port (valid/ready address stream). It also replaces free-running row/column counters with a started, back-pressured, terminating scan.

## Interface
- ADDR_W, 25: address width; all address arithmetic is modulo 2^ADDR_W.
- IDX_W, 15: row/column counter and dimension width.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  begin scan; sampled only in IDLE.
- abort  in  1  terminate scan; flush pipeline; no done pulse.
- cfg_rows  in  IDX_W  number of rows; latched on accepted start.
- cfg_cols  in  IDX_W  number of columns; latched on accepted start.
- cfg_pitch  in  IDX_W  row pitch in words; latched on accepted start.
- cfg_base  in  ADDR_W  window base address; latched on accepted start.
- addr_valid  out  1  addr/addr_row/addr_col/addr_last valid.
- addr_ready  in  1  consumer accepts the beat when high with addr_valid.
- addr  out  ADDR_W  linear address.
- addr_row  out  IDX_W  row index of the beat.
- addr_col  out  IDX_W  column index of the beat.
- addr_last  out  1  final beat of the scan (row = rows−1, col = cols−1).
- busy  out  1  scan in progress (SCAN or DRAIN).
- done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- FSM states: IDLE, SCAN, DRAIN.
- IDLE: start=1 latches cfg_*, clears row/col to 0, and moves to SCAN.
  - If cfg_rows=0 or cfg_cols=0, it moves to DRAIN instead, with no beats issued.
- SCAN: the issue stage emits (row,col) whenever stage 1 is empty or advancing.
  - col increments; at col=cols−1 it wraps to 0 and row increments.
  - Issuing (rows−1, cols−1) tags last and moves to DRAIN.
- DRAIN: waits until both pipeline stages are empty. It then pulses done and returns to IDLE.
- Pipeline stages:
  - Issue stage: row/col counters.
  - Stage 1 registers row·pitch (full product, truncated to ADDR_W), plus col, row, col, last.
  - Stage 2 registers base + product + zero-extended col (mod 2^ADDR_W) and drives the outputs.
- Each stage holds when it is full and the downstream stage is stalled. Bubbles collapse.
- Output stall: while addr_valid=1 and addr_ready=0, all addr* outputs are held stable. No beat is dropped or duplicated.
- start while busy is ignored. cfg_* changes after start have no effect.
- abort (any state):
  - Next cycle: IDLE, both stages emptied, addr_valid=0, busy=0, done=0.
  - abort has priority over start in the same cycle.
- reset has priority over abort and start.
- Reset values: addr_valid=0, addr=0, addr_row=0, addr_col=0, addr_last=0, busy=0, done=0, state IDLE.
- Reset mid-scan discards in-flight beats; no done.

## Timing
- start sampled high at edge E0 → busy=1 from E0.
- First issue at E1, stage 1 at E2, addr_valid=1 after E3: 3-cycle start-to-first-address latency.
- With addr_ready held high: one beat per cycle; rows·cols beats in consecutive cycles.
- Last beat accepted at edge Ek → done=1 and busy=0 during the cycle after Ek.
- New start accepted at the edge ending the done cycle.
- Empty scan (rows or cols = 0): start at E0 → DRAIN after E0 → done=1 after E1; addr_valid never asserts.
- Stall: addr_ready low for N cycles adds exactly N cycles to the total scan time.

## Test plan
- Basic scan: rows=2, cols=3, pitch=10, base=100, ready=1.
  - Expect addr 100,101,102,110,111,112 on consecutive cycles; first valid 3 cycles after start.
  - addr_last only on 112; done one cycle after the 112 handshake.
- Backpressure: same config, ready toggled 1,0,0,1,…
  - Expect each beat held stable while ready=0, sequence unchanged, no drops or duplicates.
  - Total time grows by the number of low-ready cycles.
- Wrap and width: base=2^25−2, rows=1, cols=4, pitch=0.
  - Expect addr 33554430, 33554431, 0, 1.
- Degenerate and ignored start:
  - cols=0 → done 2 cycles after start, no valid.
  - start pulsed while busy → no effect on the running scan.
- Abort and reset mid-scan: rows=4, cols=4, ready=1.
  - abort after the 5th beat → addr_valid=0 and busy=0 next cycle, no done; a new start works normally.
  - Repeat with reset instead of abort → all outputs at reset values.
